// File: rtl/sram_bist_pkg.sv
// Shared definitions for the SRAM march-test sequencer.
//   - bist_state_e : sequencer states (IDLE, W0, R0, W1, R1, DONE)
//   - CS_*         : chip-select codes understood by the connection mux
//   - addr_limit() : highest legal port-0 address of each test macro
package sram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W0,
        R0,
        W1,
        R1,
        DONE
    } bist_state_e;

    localparam logic [3:0] CS_SRAM0 = 4'd0;
    localparam logic [3:0] CS_SRAM1 = 4'd1;
    localparam logic [3:0] CS_SRAM2 = 4'd2;
    localparam logic [3:0] CS_SRAM3 = 4'd3;
    localparam logic [3:0] CS_SRAM4 = 4'd4;
    localparam logic [3:0] CS_NONE  = 4'hF;

    // Last valid address of each macro; zero for codes that select nothing.
    function automatic int unsigned addr_limit(input logic [3:0] cs);
        case (cs)
            CS_SRAM0: return 255;
            CS_SRAM1: return 255;
            CS_SRAM2: return 1023;
            CS_SRAM3: return 255;
            CS_SRAM4: return 511;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter used for both march directions.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   load, load_val    : load a new address (has priority over step)
//   step, down        : advance one address, downwards when down=1
//   limit             : upper terminal address
//   count             : current address (registered)
//   at_limit, at_zero : terminal-count flags for the up and down directions
module sram_bist_addr_gen
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              step,
    input  logic              down,
    input  logic [ADDR_W-1:0] limit,
    output logic [ADDR_W-1:0] count,
    output logic              at_limit,
    output logic              at_zero
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from the same edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (step) begin
            count <= down ? count - 1'b1 : count + 1'b1;
        end
    end

    // The sequencer never steps past a terminal address, so the counter never wraps.
    assign at_limit = (count == limit);
    assign at_zero  = (count == '0);

endmodule

// File: rtl/sram_bist_controller.sv
// March-test sequencer owning port 0 of one OpenRAM test macro.
// Sequence: W0 writes P ascending; R0/W1 reads P then writes ~P per address
// ascending; R1 reads ~P descending; DONE pulses and reports the result.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : one-cycle request, honoured only in IDLE
//   cs_cfg, addr_max,
//   pattern               : test configuration, latched on start
//   dout0                 : captured SRAM read data (READ_LAT after issue)
//   chip_select, csb0,
//   web0, wmask0, addr0,
//   din0                  : registered SRAM port-0 controls
//   busy, done            : test in progress / one-cycle completion pulse
//   pass, fail_addr,
//   fail_data             : result of the last completed test
module sram_bist_controller
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        cs_cfg,
    input  logic [ADDR_W-1:0] addr_max,
    input  logic [DATA_W-1:0] pattern,
    input  logic [DATA_W-1:0] dout0,
    output logic [3:0]        chip_select,
    output logic              csb0,
    output logic              web0,
    output logic [3:0]        wmask0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    // Cycle index within one read: 0 = issue, LAT = compare.
    localparam logic [2:0] LAT = 3'(READ_LAT);

    bist_state_e       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        cs_q;
    logic [ADDR_W-1:0] amax_q;
    logic [DATA_W-1:0] pat_q;

    logic              ag_load, ag_step, ag_down;
    logic              at_limit, at_zero;
    logic              accept, miscompare, finish_ok;
    logic [DATA_W-1:0] exp_word;

    // Next values of the registered SRAM-side outputs.
    logic [3:0]        cs_d;
    logic              csb_d, web_d, busy_d, done_d;
    logic [3:0]        wmask_d;
    logic [DATA_W-1:0] din_d;
    logic [3:0]        cs_eff;
    logic [DATA_W-1:0] pat_eff;

    // addr0 is the counter register itself, so it is a registered output.
    sram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (ag_load),
        .load_val ('0),
        .step     (ag_step),
        .down     (ag_down),
        .limit    (amax_q),
        .count    (addr0),
        .at_limit (at_limit),
        .at_zero  (at_zero)
    );

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        ag_load    = 1'b0;
        ag_step    = 1'b0;
        ag_down    = 1'b0;
        accept     = 1'b0;
        miscompare = 1'b0;
        finish_ok  = 1'b0;
        exp_word   = (state_q == R1) ? ~pat_q : pat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = W0;
                    cnt_d   = '0;
                    ag_load = 1'b1;
                end
            end
            W0: begin
                if (at_limit) begin
                    state_d = R0;
                    cnt_d   = '0;
                    ag_load = 1'b1;
                end else begin
                    ag_step = 1'b1;
                end
            end
            R0: begin
                if (cnt_q != LAT) begin
                    cnt_d = cnt_q + 3'd1;
                end else if (dout0 != exp_word) begin
                    miscompare = 1'b1;
                    state_d    = DONE;
                end else begin
                    state_d = W1;
                end
            end
            W1: begin
                cnt_d = '0;
                // After the last W1 the counter already sits on addr_max,
                // which is exactly where the descending R1 pass starts.
                if (at_limit) begin
                    state_d = R1;
                end else begin
                    state_d = R0;
                    ag_step = 1'b1;
                end
            end
            R1: begin
                if (cnt_q != LAT) begin
                    cnt_d = cnt_q + 3'd1;
                end else if (dout0 != exp_word) begin
                    miscompare = 1'b1;
                    state_d    = DONE;
                end else if (at_zero) begin
                    finish_ok = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d   = '0;
                    ag_step = 1'b1;
                    ag_down = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state, so the registered outputs describe
    // the access performed during the cycle the FSM is entering. On the
    // accept edge the configuration registers are still loading, so the raw
    // inputs are used instead.
    always_comb begin
        cs_eff  = (state_q == IDLE) ? cs_cfg  : cs_q;
        pat_eff = (state_q == IDLE) ? pattern : pat_q;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = 4'h0;
        din_d   = '0;
        done_d  = 1'b0;

        case (state_d)
            W0: begin
                csb_d   = 1'b0;
                web_d   = 1'b0;
                wmask_d = 4'hF;
                din_d   = pat_eff;
            end
            W1: begin
                csb_d   = 1'b0;
                web_d   = 1'b0;
                wmask_d = 4'hF;
                din_d   = ~pat_eff;
            end
            R0, R1:  csb_d  = (cnt_d != '0);
            DONE:    done_d = 1'b1;
            default: ;
        endcase

        busy_d = state_d inside {W0, R0, W1, R1};
        cs_d   = busy_d ? cs_eff : CS_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cs_q        <= CS_NONE;
            amax_q      <= '0;
            pat_q       <= '0;
            chip_select <= CS_NONE;
            csb0        <= 1'b1;
            web0        <= 1'b1;
            wmask0      <= 4'h0;
            din0        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chip_select <= cs_d;
            csb0        <= csb_d;
            web0        <= web_d;
            wmask0      <= wmask_d;
            din0        <= din_d;
            busy        <= busy_d;
            done        <= done_d;

            if (accept) begin
                cs_q      <= cs_cfg;
                amax_q    <= addr_max;
                pat_q     <= pattern;
                pass      <= 1'b0;
                fail_addr <= '0;
                fail_data <= '0;
            end else if (miscompare) begin
                // Only the first miscompare is recorded: the test aborts here.
                pass      <= 1'b0;
                fail_addr <= addr0;
                fail_data <= dout0;
            end else if (finish_ok) begin
                pass <= 1'b1;
            end
        end
    end

endmodule
